// File: rtl/word_byte_serializer.sv
// Purpose : serializes a held 32-bit word into 1..4 bytes over a valid/ready byte stream.
// Latency : first byte appears the cycle after the word is accepted; then one byte per cycle.
// Backpres: out_ready low freezes the current byte. A new word is only taken when the
//           serializer is idle or its last byte is leaving. That accept path is
//           combinational from out_ready, so back-to-back words have no idle cycle between them.
//
// Ports:
//   clk, reset             rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready      word handshake; in_data holds the word, in_len = bytes-1
//   out_valid/out_ready    byte handshake; out_data = byte, out_last marks final byte of word
//   busy                   a word is held (SEND state)
//   word_count             fully transmitted words, wraps modulo 2^16
module word_byte_serializer #(
    parameter int MSB_FIRST = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic [1:0]  in_len,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        busy,
    output logic [15:0] word_count
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] word_q;
    logic [31:0] word_next;
    logic [1:0]  remaining;
    logic [1:0]  remaining_next;
    logic [1:0]  index;
    logic [1:0]  index_next;
    logic [15:0] count_next;

    logic byte_fire;
    logic last_fire;
    logic accept;

    assign out_valid = (state == SEND);
    assign busy      = (state == SEND);
    assign out_last  = out_valid && (remaining == 2'd0);
    // Gated to zero when idle so the idle/reset value of out_data is 8'h00.
    assign out_data  = out_valid ? word_q[{index, 3'b000} +: 8] : 8'h00;

    assign byte_fire = out_valid && out_ready;
    assign last_fire = byte_fire && out_last;
    // Taking a new word on the same edge the last byte leaves gives zero-bubble streaming.
    assign in_ready  = !reset && ((state == IDLE) || last_fire);
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            word_q     <= 32'h0000_0000;
            remaining  <= 2'd0;
            index      <= 2'd0;
            word_count <= 16'h0000;
        end else begin
            state      <= state_next;
            word_q     <= word_next;
            remaining  <= remaining_next;
            index      <= index_next;
            word_count <= count_next;
        end
    end

    always_comb begin
        state_next     = state;
        word_next      = word_q;
        remaining_next = remaining;
        index_next     = index;
        count_next     = word_count;

        if (last_fire) begin
            count_next = word_count + 16'd1;
            state_next = IDLE;
        end else if (byte_fire) begin
            remaining_next = remaining - 2'd1;
            index_next     = (MSB_FIRST != 0) ? (index - 2'd1) : (index + 2'd1);
        end

        // A load overrides the IDLE transition when it coincides with the last byte.
        if (accept) begin
            state_next     = SEND;
            word_next      = in_data;
            remaining_next = in_len;
            index_next     = (MSB_FIRST != 0) ? in_len : 2'd0;
        end
    end

endmodule

// File: tb/tb_word_byte_serializer.sv
module tb_word_byte_serializer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic [1:0]  in_len;
    logic        out_ready;

    logic        m_in_ready, m_out_valid, m_out_last, m_busy;
    logic [7:0]  m_out_data;
    logic [15:0] m_word_count;
    logic        l_in_ready, l_out_valid, l_out_last, l_busy;
    logic [7:0]  l_out_data;
    logic [15:0] l_word_count;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_wc;

    word_byte_serializer #(.MSB_FIRST(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(m_in_ready),
        .in_data(in_data), .in_len(in_len), .out_valid(m_out_valid), .out_ready(out_ready),
        .out_data(m_out_data), .out_last(m_out_last), .busy(m_busy), .word_count(m_word_count)
    );

    word_byte_serializer #(.MSB_FIRST(0)) dut_lsb (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(l_in_ready),
        .in_data(in_data), .in_len(in_len), .out_valid(l_out_valid), .out_ready(out_ready),
        .out_data(l_out_data), .out_last(l_out_last), .busy(l_busy), .word_count(l_word_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_data = 32'h0; in_len = 2'd0; out_ready = 1'b1;
        tick(); tick();
        @(negedge clk);
        checks++; if (m_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", m_out_valid); end
        checks++; if (m_out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h exp 00", m_out_data); end
        checks++; if (m_out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b exp 0", m_out_last); end
        checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", m_busy); end
        checks++; if (m_word_count !== 16'h0000) begin errors++; $display("FAIL reset_word_count got %h exp 0000", m_word_count); end
        checks++; if (m_in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_high got %b exp 0", m_in_ready); end
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (m_in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got %b exp 1", m_in_ready); end
        checks++; if (l_in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready_lsb got %b exp 1", l_in_ready); end
        tick();
        exp_wc = 16'h0000;
    endtask

    task automatic test_basic();
        logic [7:0] em [4];
        logic [7:0] el [4];
        em = '{8'h11, 8'h22, 8'h33, 8'h44};
        el = '{8'h44, 8'h33, 8'h22, 8'h11};
        in_valid = 1'b1; in_data = 32'h11223344; in_len = 2'd3; out_ready = 1'b1;
        @(negedge clk);
        checks++; if (m_in_ready !== 1'b1) begin errors++; $display("FAIL basic_idle_in_ready got %b exp 1", m_in_ready); end
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (m_out_valid !== 1'b1 || m_out_data !== em[i]) begin errors++; $display("FAIL basic_msb_byte%0d got v%b %h exp v1 %h", i, m_out_valid, m_out_data, em[i]); end
            checks++; if (m_out_last !== (i == 3)) begin errors++; $display("FAIL basic_msb_last%0d got %b exp %b", i, m_out_last, (i == 3)); end
            checks++; if (l_out_data !== el[i] || l_out_last !== (i == 3)) begin errors++; $display("FAIL basic_lsb_byte%0d got %h/%b exp %h/%b", i, l_out_data, l_out_last, el[i], (i == 3)); end
            tick();
        end
        exp_wc = exp_wc + 16'd1;
        @(negedge clk);
        checks++; if (m_busy !== 1'b0 || m_out_valid !== 1'b0) begin errors++; $display("FAIL basic_idle_after got busy %b valid %b exp 0 0", m_busy, m_out_valid); end
        checks++; if (m_word_count !== exp_wc) begin errors++; $display("FAIL basic_word_count got %h exp %h", m_word_count, exp_wc); end
    endtask

    task automatic test_lengths();
        logic [7:0] em [2];
        logic [7:0] el [2];
        em = '{8'h33, 8'h44};
        el = '{8'h44, 8'h33};
        in_valid = 1'b1; in_data = 32'h11223344; in_len = 2'd1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (m_out_data !== em[i] || m_out_last !== (i == 1)) begin errors++; $display("FAIL len1_msb_byte%0d got %h/%b exp %h/%b", i, m_out_data, m_out_last, em[i], (i == 1)); end
            checks++; if (l_out_data !== el[i] || l_out_last !== (i == 1)) begin errors++; $display("FAIL len1_lsb_byte%0d got %h/%b exp %h/%b", i, l_out_data, l_out_last, el[i], (i == 1)); end
            tick();
        end
        @(negedge clk);
        checks++; if (m_out_valid !== 1'b0) begin errors++; $display("FAIL len1_done got valid %b exp 0", m_out_valid); end
        in_valid = 1'b1; in_len = 2'd0;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (m_out_valid !== 1'b1 || m_out_data !== 8'h44 || m_out_last !== 1'b1) begin errors++; $display("FAIL len0_msb got v%b %h l%b exp v1 44 l1", m_out_valid, m_out_data, m_out_last); end
        checks++; if (l_out_data !== 8'h44 || l_out_last !== 1'b1) begin errors++; $display("FAIL len0_lsb got %h l%b exp 44 l1", l_out_data, l_out_last); end
        tick();
        exp_wc = exp_wc + 16'd2;
        @(negedge clk);
        checks++; if (m_word_count !== exp_wc || m_busy !== 1'b0) begin errors++; $display("FAIL lengths_word_count got %h busy %b exp %h busy 0", m_word_count, m_busy, exp_wc); end
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1; in_data = 32'h11223344; in_len = 2'd3; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (m_out_data !== 8'h11) begin errors++; $display("FAIL bp_first got %h exp 11", m_out_data); end
        tick();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hDEADBEEF; in_len = 2'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (m_out_valid !== 1'b1 || m_out_data !== 8'h22 || m_out_last !== 1'b0) begin errors++; $display("FAIL bp_hold%0d got v%b %h l%b exp v1 22 l0", i, m_out_valid, m_out_data, m_out_last); end
            checks++; if (m_in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready%0d got %b exp 0", i, m_in_ready); end
            checks++; if (l_out_data !== 8'h33) begin errors++; $display("FAIL bp_hold_lsb%0d got %h exp 33", i, l_out_data); end
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (m_out_data !== 8'h22) begin errors++; $display("FAIL bp_release got %h exp 22", m_out_data); end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (m_out_data !== 8'h33) begin errors++; $display("FAIL bp_resume got %h exp 33", m_out_data); end
        tick();
        @(negedge clk);
        checks++; if (m_out_data !== 8'h44 || m_out_last !== 1'b1) begin errors++; $display("FAIL bp_last got %h l%b exp 44 l1", m_out_data, m_out_last); end
        tick();
        exp_wc = exp_wc + 16'd1;
        @(negedge clk);
        checks++; if (m_busy !== 1'b0 || m_word_count !== exp_wc) begin errors++; $display("FAIL bp_not_consumed got busy %b wc %h exp busy 0 wc %h", m_busy, m_word_count, exp_wc); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] em [5];
        logic [7:0] el [5];
        em = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h55};
        el = '{8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h55};
        in_valid = 1'b1; in_data = 32'hAABBCCDD; in_len = 2'd3; out_ready = 1'b1;
        tick();
        in_data = 32'h00000055; in_len = 2'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (m_out_valid !== 1'b1 || m_out_data !== em[i]) begin errors++; $display("FAIL b2b_msb%0d got v%b %h exp v1 %h", i, m_out_valid, m_out_data, em[i]); end
            checks++; if (l_out_data !== el[i]) begin errors++; $display("FAIL b2b_lsb%0d got %h exp %h", i, l_out_data, el[i]); end
            checks++; if (m_in_ready !== (i >= 3)) begin errors++; $display("FAIL b2b_in_ready%0d got %b exp %b", i, m_in_ready, (i >= 3)); end
            checks++; if (m_out_last !== (i >= 3)) begin errors++; $display("FAIL b2b_last%0d got %b exp %b", i, m_out_last, (i >= 3)); end
            tick();
            if (i == 3) in_valid = 1'b0;
        end
        exp_wc = exp_wc + 16'd2;
        @(negedge clk);
        checks++; if (m_word_count !== exp_wc || m_busy !== 1'b0) begin errors++; $display("FAIL b2b_word_count got %h busy %b exp %h busy 0", m_word_count, m_busy, exp_wc); end
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1; in_data = 32'h11223344; in_len = 2'd3; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        @(negedge clk);
        checks++; if (m_out_data !== 8'h33 || m_out_valid !== 1'b1) begin errors++; $display("FAIL areset_pre got v%b %h exp v1 33", m_out_valid, m_out_data); end
        tick();
        #2 reset = 1'b1;
        #1;
        checks++; if (m_out_valid !== 1'b0 || m_busy !== 1'b0) begin errors++; $display("FAIL areset_drop got valid %b busy %b exp 0 0", m_out_valid, m_busy); end
        checks++; if (m_word_count !== 16'h0000 || m_out_data !== 8'h00) begin errors++; $display("FAIL areset_clear got wc %h data %h exp 0000 00", m_word_count, m_out_data); end
        checks++; if (m_in_ready !== 1'b0) begin errors++; $display("FAIL areset_in_ready got %b exp 0", m_in_ready); end
        tick(); tick();
        reset = 1'b0;
        exp_wc = 16'h0000;
        in_valid = 1'b1; in_data = 32'h000000EE; in_len = 2'd0;
        @(negedge clk);
        checks++; if (m_in_ready !== 1'b1 || m_out_valid !== 1'b0) begin errors++; $display("FAIL areset_idle got rdy %b valid %b exp 1 0", m_in_ready, m_out_valid); end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (m_out_valid !== 1'b1 || m_out_data !== 8'hEE || m_out_last !== 1'b1) begin errors++; $display("FAIL areset_post_word got v%b %h l%b exp v1 EE l1", m_out_valid, m_out_data, m_out_last); end
        tick();
        exp_wc = exp_wc + 16'd1;
        @(negedge clk);
        checks++; if (m_word_count !== exp_wc) begin errors++; $display("FAIL areset_word_count got %h exp %h", m_word_count, exp_wc); end
    endtask

    task automatic test_wrap();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        in_valid = 1'b1; in_len = 2'd0; out_ready = 1'b1; in_data = 32'h0;
        tick();
        for (int i = 1; i < 65536; i++) begin
            in_data = i;
            tick();
            if (i == 256) begin
                checks++; if (m_word_count !== 16'h0100) begin errors++; $display("FAIL wrap_mid got %h exp 0100", m_word_count); end
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (m_word_count !== 16'hFFFF || m_out_last !== 1'b1) begin errors++; $display("FAIL wrap_pre got %h l%b exp FFFF l1", m_word_count, m_out_last); end
        tick();
        @(negedge clk);
        checks++; if (m_word_count !== 16'h0000 || m_busy !== 1'b0) begin errors++; $display("FAIL wrap_zero got %h busy %b exp 0000 busy 0", m_word_count, m_busy); end
        checks++; if (l_word_count !== 16'h0000) begin errors++; $display("FAIL wrap_zero_lsb got %h exp 0000", l_word_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lengths();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
